// File: rtl/fetch_buffer.sv
// fetch_buffer: dual-issue instruction queue between fetch and decode; 0/1/2 pops per cycle.
// Define FETCH_BUF_PERF_EN to add saturating full/empty cycle counters.
module fetch_buffer #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [31:0]      pc_i,
  input  logic [63:0]      idata_i,
  output logic             full_o,
  output logic [31:0]      inst0_o,
  output logic [31:0]      inst1_o,
  output logic [31:0]      pc0_o,
  output logic [31:0]      pc1_o,
  output logic             valid0_o,
  output logic             valid1_o,
  input  logic [1:0]       pop_i,
`ifdef FETCH_BUF_PERF_EN
  output logic [31:0]      full_cycles_o,
  output logic [31:0]      empty_cycles_o,
`endif
  output logic [PTR_W:0]   count_o
);
  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [PTR_W:0] count, pop_clip, pop_eff, push_add;
  logic push_acc;
  assign rd_nxt = rd_ptr + PTR_W'(1);
  assign wr_nxt = wr_ptr + PTR_W'(1);
  assign valid0_o = count != '0;
  assign valid1_o = count > (PTR_W+1)'(1);
  assign full_o = count > (PTR_W+1)'(DEPTH - 2);
  assign count_o = count;
  assign inst0_o = valid0_o ? mem_inst[rd_ptr] : '0;
  assign pc0_o = valid0_o ? mem_pc[rd_ptr] : '0;
  assign inst1_o = valid1_o ? mem_inst[rd_nxt] : '0;
  assign pc1_o = valid1_o ? mem_pc[rd_nxt] : '0;
  // full is judged on pre-pop occupancy: no same-cycle pop credit for a push
  assign push_acc = push_i && !full_o;
  assign push_add = push_acc ? (PTR_W+1)'(2) : '0;
  assign pop_clip = pop_i[1] ? (PTR_W+1)'(2) : (PTR_W+1)'(pop_i[0]);
  assign pop_eff = (count < pop_clip) ? count : pop_clip;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_eff);
      wr_ptr <= wr_ptr + PTR_W'(push_add);
      count <= count + push_add - pop_eff;
    end
  end
  always_ff @(posedge clock_i) begin
    if (push_acc && !flush_i) begin
      mem_inst[wr_ptr] <= idata_i[31:0];
      mem_pc[wr_ptr] <= pc_i;
      mem_inst[wr_nxt] <= idata_i[63:32];
      mem_pc[wr_nxt] <= pc_i + 32'd4;
    end
  end
`ifdef FETCH_BUF_PERF_EN
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      full_cycles_o <= '0;
      empty_cycles_o <= '0;
    end else begin
      if (push_i && full_o && full_cycles_o != '1) full_cycles_o <= full_cycles_o + 32'd1;
      if (count == '0 && !flush_i && empty_cycles_o != '1) empty_cycles_o <= empty_cycles_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer at DEPTH=8.
module tb_fetch_buffer;
  logic clock_i = 0, reset_i = 1, flush_i = 0, push_i = 0;
  logic [31:0] pc_i = 0;
  logic [63:0] idata_i = 0;
  logic [1:0] pop_i = 0;
  logic full_o, valid0_o, valid1_o;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic [3:0] count_o;
`ifdef FETCH_BUF_PERF_EN
  logic [31:0] full_cycles_o, empty_cycles_o;
`endif
  int tests = 0, fails = 0;
  fetch_buffer #(.DEPTH(8)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .push_i(push_i),
    .pc_i(pc_i), .idata_i(idata_i), .full_o(full_o), .inst0_o(inst0_o),
    .inst1_o(inst1_o), .pc0_o(pc0_o), .pc1_o(pc1_o), .valid0_o(valid0_o),
    .valid1_o(valid1_o), .pop_i(pop_i),
`ifdef FETCH_BUF_PERF_EN
    .full_cycles_o(full_cycles_o), .empty_cycles_o(empty_cycles_o),
`endif
    .count_o(count_o));
  always #5 clock_i = ~clock_i;

  task automatic step;
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic p, input logic [31:0] pc, input logic [1:0] pop);
    push_i = p;
    pc_i = pc;
    idata_i = {pc + 32'hA000_0004, pc + 32'hA000_0000};
    pop_i = pop;
  endtask

  task automatic test_reset;
    step;
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count_o); end
    tests++; if ({valid0_o, valid1_o, full_o} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {valid0_o, valid1_o, full_o}); end
    tests++; if ({inst0_o, pc0_o, inst1_o, pc1_o} !== 128'd0) begin fails++; $display("FAIL reset_data got %h exp 0", {inst0_o, pc0_o, inst1_o, pc1_o}); end
    reset_i = 0;
  endtask

  task automatic test_basic;
    push_i = 1; pc_i = 32'h100; idata_i = 64'h00500093_00100113; pop_i = 0;
    step;
    drive(0, 0, 0);
    tests++; if ({valid0_o, valid1_o} !== 2'b11) begin fails++; $display("FAIL basic_valid got %b exp 11", {valid0_o, valid1_o}); end
    tests++; if (inst0_o !== 32'h00100113 || pc0_o !== 32'h100) begin fails++; $display("FAIL basic_slot0 got %h/%h exp 00100113/100", inst0_o, pc0_o); end
    tests++; if (inst1_o !== 32'h00500093 || pc1_o !== 32'h104) begin fails++; $display("FAIL basic_slot1 got %h/%h exp 00500093/104", inst1_o, pc1_o); end
    tests++; if (count_o !== 4'd2) begin fails++; $display("FAIL basic_count got %0d exp 2", count_o); end
    drive(0, 0, 2);
    step;
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL basic_drain got %0d exp 0", count_o); end
  endtask

  task automatic test_fill;
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'(8 * k), 0);
      step;
    end
    tests++; if (count_o !== 4'd8 || full_o !== 1'b1) begin fails++; $display("FAIL fill_full got count %0d full %b exp 8/1", count_o, full_o); end
    drive(1, 32'h20, 0);
    step;
    tests++; if (count_o !== 4'd8) begin fails++; $display("FAIL fill_ignored got %0d exp 8", count_o); end
    drive(0, 0, 2);
    for (int k = 0; k < 4; k++) begin
      tests++; if (pc0_o !== 32'(8 * k) || pc1_o !== 32'(8 * k + 4) || inst0_o !== 32'(8 * k) + 32'hA000_0000) begin
        fails++; $display("FAIL fill_order%0d got %h/%h exp %h/%h", k, pc0_o, pc1_o, 8 * k, 8 * k + 4);
      end
      step;
    end
    tests++; if (count_o !== 4'd0 || valid0_o !== 1'b0) begin fails++; $display("FAIL fill_empty got %0d/%b exp 0/0", count_o, valid0_o); end
  endtask

  task automatic test_single_pop;
    drive(1, 32'h40, 0);
    step;
    drive(0, 0, 1);
    step;
    tests++; if (pc0_o !== 32'h44 || inst0_o !== 32'hA000_0044 || valid1_o !== 1'b0 || count_o !== 4'd1) begin
      fails++; $display("FAIL single_pop got pc0 %h inst0 %h v1 %b count %0d exp 44/a0000044/0/1", pc0_o, inst0_o, valid1_o, count_o);
    end
    drive(1, 32'h48, 1);
    step;
    tests++; if (pc0_o !== 32'h48 || pc1_o !== 32'h4C || count_o !== 4'd2) begin
      fails++; $display("FAIL push_pop got %h/%h count %0d exp 48/4c/2", pc0_o, pc1_o, count_o);
    end
    drive(0, 0, 2);
    step;
  endtask

  task automatic test_wrap;
    logic [31:0] q[$];
    logic [31:0] nxt = 32'h2000;
    logic [1:0] pops[5] = '{2'd1, 2'd0, 2'd3, 2'd1, 2'd2};
    int eff, guard;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h1000 + 32'(8 * i), 2);
      step;
      tests++; if (count_o !== 4'd2 || pc0_o !== 32'h1000 + 32'(8 * i) || pc1_o !== 32'h1004 + 32'(8 * i)) begin
        fails++; $display("FAIL wrap_stream%0d got %h/%h count %0d exp %h", i, pc0_o, pc1_o, count_o, 32'h1000 + 32'(8 * i));
      end
    end
    drive(0, 0, 2);
    step;
    for (int i = 0; i < 30; i++) begin
      drive(1, nxt, pops[i % 5]);
      eff = (pops[i % 5] == 0) ? 0 : (pops[i % 5] == 1) ? 1 : 2;
      if (eff > q.size()) eff = q.size();
      tests++; if (q.size() > 0 && pc0_o !== q[0]) begin fails++; $display("FAIL wrap_mix_pc0 c%0d got %h exp %h", i, pc0_o, q[0]); end
      tests++; if (q.size() > 1 && pc1_o !== q[1]) begin fails++; $display("FAIL wrap_mix_pc1 c%0d got %h exp %h", i, pc1_o, q[1]); end
      step;
      for (int k = 0; k < eff; k++) void'(q.pop_front());
      if (q.size() + eff <= 6) begin
        q.push_back(nxt); q.push_back(nxt + 4); nxt += 8;
      end
      tests++; if (count_o !== 4'(q.size())) begin fails++; $display("FAIL wrap_mix_count c%0d got %0d exp %0d", i, count_o, q.size()); end
    end
    drive(0, 0, 2);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      tests++; if (pc0_o !== q[0]) begin fails++; $display("FAIL wrap_drain got %h exp %h", pc0_o, q[0]); end
      step;
      void'(q.pop_front());
      if (q.size() > 0) void'(q.pop_front());
      guard++;
    end
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL wrap_final got %0d exp 0", count_o); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h500 + 32'(8 * k), 0);
      step;
    end
    tests++; if (count_o !== 4'd6) begin fails++; $display("FAIL flush_pre got %0d exp 6", count_o); end
    drive(1, 32'h200, 2);
    flush_i = 1;
    step;
    flush_i = 0;
    drive(0, 0, 0);
    tests++; if (count_o !== 4'd0 || {valid0_o, valid1_o, full_o} !== 3'b000) begin
      fails++; $display("FAIL flush_state got count %0d flags %b exp 0/000", count_o, {valid0_o, valid1_o, full_o});
    end
    step;
    tests++; if (valid0_o !== 1'b0 || pc0_o === 32'h200) begin fails++; $display("FAIL flush_discard got v0 %b pc0 %h exp 0/0", valid0_o, pc0_o); end
    drive(1, 32'h600, 0);
    step;
    tests++; if (pc0_o !== 32'h600 || count_o !== 4'd2) begin fails++; $display("FAIL flush_after got %h count %0d exp 600/2", pc0_o, count_o); end
    drive(0, 0, 2);
    step;
  endtask

  task automatic test_async_reset;
    drive(1, 32'h700, 0);
    step;
    drive(1, 32'h708, 0);
    step;
    drive(0, 0, 0);
    tests++; if (count_o !== 4'd4) begin fails++; $display("FAIL areset_pre got %0d exp 4", count_o); end
    #2 reset_i = 1;
    #1;
    tests++; if (count_o !== 4'd0 || {valid0_o, valid1_o, full_o} !== 3'b000 || {inst0_o, pc0_o} !== 64'd0) begin
      fails++; $display("FAIL areset_async got count %0d flags %b pc0 %h exp 0/000/0", count_o, {valid0_o, valid1_o, full_o}, pc0_o);
    end
    step;
    reset_i = 0;
    drive(1, 32'h300, 0);
    step;
    drive(0, 0, 0);
    tests++; if (pc0_o !== 32'h300 || valid0_o !== 1'b1 || count_o !== 4'd2) begin
      fails++; $display("FAIL areset_after got %h v0 %b count %0d exp 300/1/2", pc0_o, valid0_o, count_o);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_single_pop;
    test_wrap;
    test_flush;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between the F2/IMEM stage and the decode stage of the dual-issue pipeline.
- Accepts a 64-bit fetch packet (two 32-bit instructions) plus its PC each cycle.
- Presents the two oldest instructions, with their PCs, to the decode slots.
- Lets decode consume 0, 1 or 2 instructions per cycle, so a single-issue cycle does not refetch or drop the second slot.
- Back-pressures the frontend when it cannot absorb another packet.

Parameters:
DEPTH, 8, instruction entries in the circular queue; power of two, >= 4.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clock_i  in  1  pipeline clock, rising edge
reset_i  in  1  asynchronous active-high reset
flush_i  in  1  discard all buffered instructions (branch redirect)
push_i   in  1  fetch packet valid (frontend write enable)
pc_i     in  32  PC of the packet's low word; must be 8-byte aligned
idata_i  in  64  [31:0] = inst at pc_i, [63:32] = inst at pc_i+4
full_o   out  1  asserted when free entries < 2; frontend must not push
inst0_o  out  32  oldest instruction
inst1_o  out  32  second-oldest instruction
pc0_o    out  32  PC of inst0_o
pc1_o    out  32  PC of inst1_o
valid0_o out  1  inst0_o/pc0_o valid
valid1_o out  1  inst1_o/pc1_o valid
pop_i    in  2  instructions consumed by decode this cycle (0, 1, 2; 3 is treated as 2)
count_o  out  PTR_W+1  current occupancy

Behaviour:
- Storage: DEPTH entries of {inst[31:0], pc[31:0]}.
  - Read pointer rd_ptr and write pointer wr_ptr, each PTR_W bits, wrapping modulo DEPTH.
  - Occupancy count in PTR_W+1 bits, range 0..DEPTH.
- Reset (async, on reset_i high):
  - rd_ptr=0, wr_ptr=0, count=0.
  - All outputs 0; full_o=0.
  - Entry contents are don't-care.
  - Reset asserted mid-operation drops all contents immediately.
- Outputs are combinational from registered state only:
  - inst0_o/pc0_o = entry[rd_ptr]; inst1_o/pc1_o = entry[rd_ptr+1].
  - valid0_o = (count >= 1); valid1_o = (count >= 2).
  - When an output slot is invalid, its inst and pc read as 0, so decode sees a NOP-equivalent bubble.
  - full_o = (count > DEPTH-2).
  - count_o = count.
- Pop:
  - Effective pop = min(pop_i clipped to 2, count).
  - Popping more than is valid is silently clipped; no underflow.
  - rd_ptr advances by the effective pop.
- Push:
  - Accepted when push_i=1 and full_o=0, with full_o evaluated on pre-pop state. There is no same-cycle pop-to-push credit.
  - Accepted push writes entry[wr_ptr] = {idata_i[31:0], pc_i} and entry[wr_ptr+1] = {idata_i[63:32], pc_i+4}.
  - wr_ptr advances by 2.
  - push_i while full_o=1 is ignored; no state changes from the push.
- Count update: count_next = count + 2*push_accepted - effective_pop. Simultaneous push and pop are both applied in the same cycle.
- Latency: a packet pushed in cycle N is visible on outputs in cycle N+1 at the earliest.
- Ordering: instructions leave in strict program order of arrival. A 1-pop leaves the second instruction as the new inst0_o on the next cycle.
- Wrap-around: pointer increments of 1 and 2 wrap modulo DEPTH. Because DEPTH is even and push always adds 2, wr_ptr stays even; rd_ptr may be odd.
- Flush (synchronous, priority over push and pop in the same cycle):
  - rd_ptr=wr_ptr=0, count=0.
  - The packet presented with flush_i is discarded.
  - Next cycle: valid0_o=valid1_o=0 and full_o=0.
- No combinational path from pop_i or push_i to any output.

Optional Feature:
FETCH_BUF_PERF_EN
- Defined: adds outputs full_cycles_o[31:0] and empty_cycles_o[31:0].
  - full_cycles_o counts cycles with push_i=1 && full_o=1.
  - empty_cycles_o counts cycles with count==0 && !flush_i.
  - Both cleared by reset_i, not by flush_i; saturate at 32'hFFFF_FFFF.
- Not defined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then push pc_i=0x100, idata_i=0x00500093_00100113.
  -> Next cycle: valid0/1=1, inst0=0x00100113 with pc0=0x100, inst1=0x00500093 with pc1=0x104, count_o=2.
- Push 4 packets (pc 0x0,0x8,0x10,0x18) with pop_i=0 at DEPTH=8.
  -> count_o=8, full_o=1; a 5th push (pc 0x20) is ignored.
  -> Then pop_i=2 for 4 cycles returns PCs 0x0..0x1C in order.
- Load pc 0x40 packet, pop_i=1.
  -> inst0 becomes the former inst1 (pc0=0x44), valid1=0, count_o=1.
  -> Push pc 0x48 with pop_i=1 in the same cycle: next cycle pc0=0x48, pc1=0x4C, count_o=2.
- Run 20 cycles of push with pop_i=2.
  -> Pointers wrap; PCs exit strictly sequential.
  -> count_o stays 2 from the second cycle onward.
  -> Single pops interleaved to make rd_ptr odd across the wrap give no lost or duplicated PC.
- With count_o=6, assert flush_i together with push_i (pc 0x200) and pop_i=2.
  -> Next cycle: count_o=0, valid0=valid1=0, full_o=0; pc 0x200 is never output.
- Assert reset_i asynchronously mid-cycle with count_o=4.
  -> Outputs go 0 immediately, without waiting for a clock edge.
  -> After release, the first push (pc 0x300) appears at pc0 next cycle.
